// File: rtl/enemy_pkg.sv
// Shared state encoding, spawn types and type-selection helpers for the enemy wave scheduler.
// Build option SPAWN_LFSR_EN adds the LFSR seed, taps and random type mapping.
package enemy_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned WAVE_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    QIdle     = 5'b00001,
    QCooldown = 5'b00010,
    QSpawn    = 5'b00100,
    QWaveWait = 5'b01000,
    QWaveGap  = 5'b10000
  } state_t;

  localparam logic [TYPE_W-1:0] TYPE_NONE  = 2'b00;
  localparam logic [TYPE_W-1:0] TYPE_BASIC = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_MID   = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_BOSS  = 2'b11;

  localparam logic [WAVE_W-1:0] WAVE_MAX = 4'd15;

  // Fixed pattern: boss closes every wave from wave 2 on, odd spawns are mid from wave 1 on.
  function automatic logic [TYPE_W-1:0] det_type(input logic [WAVE_W-1:0] wave,
                                                 input logic k_odd,
                                                 input logic k_last);
    if (wave >= 4'd2 && k_last) return TYPE_BOSS;
    if (wave >= 4'd1 && k_odd) return TYPE_MID;
    return TYPE_BASIC;
  endfunction

`ifdef SPAWN_LFSR_EN
  localparam int unsigned LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [TYPE_W-1:0] lfsr_type(input logic [2:0] sel,
                                                  input logic [WAVE_W-1:0] wave);
    if (sel == 3'd7) begin
      if (wave >= 4'd2) return TYPE_BOSS;
      if (wave >= 4'd1) return TYPE_MID;
      return TYPE_BASIC;
    end
    if (sel >= 3'd5 && wave >= 4'd1) return TYPE_MID;
    return TYPE_BASIC;
  endfunction
`endif

endpackage

// File: rtl/rr_slot_arbiter.sv
// Combinational round-robin picker: first requesting slot at or after ptr, wrapping,
// plus the pointer to resume from after that grant.
module rr_slot_arbiter #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned PTR_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_SLOTS-1:0] grant,
  output logic [PTR_W-1:0]     next_ptr
);

  logic              found;
  logic [PTR_W-1:0]  idx;
  int unsigned       sum;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    sum      = 0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      sum = 32'(ptr) + k;
      if (sum >= NUM_SLOTS) sum = sum - NUM_SLOTS;
      idx = PTR_W'(sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (sum == NUM_SLOTS - 1) ? '0 : PTR_W'(sum + 1);
      end
    end
  end

endmodule

// File: rtl/enemy_wave_scheduler.sv
// Enemy slot sequencer: paces spawns per wave, grants slots round-robin, and emits move/damage strobes.
// Define SPAWN_LFSR_EN to pick spawn types from an 8-bit LFSR instead of the fixed pattern.
module enemy_wave_scheduler
  import enemy_pkg::*;
#(
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned SPAWN_COOLDOWN = 8,
  parameter int unsigned MOVE_DIV       = 4,
  parameter int unsigned WAVE_LEN       = 3,
  parameter int unsigned WAVE_GAP       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] slotDead,
  output logic [NUM_SLOTS-1:0] canSpawn,
  output logic [TYPE_W-1:0]    spawnType,
  output logic                 moveSCEN,
  output logic                 damageSCEN,
  output logic [WAVE_W-1:0]    waveNum,
  output logic                 waveDone
);

  localparam int unsigned PTR_W   = $clog2(NUM_SLOTS);
  localparam int unsigned DIV_W   = $clog2(MOVE_DIV);
  localparam int unsigned CNT_MAX = (SPAWN_COOLDOWN > WAVE_GAP) ? SPAWN_COOLDOWN : WAVE_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned SPAWN_W = 4;

  localparam logic [CNT_W-1:0]   COOL_LOAD  = CNT_W'(SPAWN_COOLDOWN - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'(WAVE_GAP - 1);
  localparam logic [SPAWN_W-1:0] LAST_K     = SPAWN_W'(WAVE_LEN - 1);
  localparam logic [SPAWN_W-1:0] WAVE_COUNT = SPAWN_W'(WAVE_LEN);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(MOVE_DIV - 1);

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [SPAWN_W-1:0]    spawn_cnt, spawn_cnt_d;
  logic [NUM_SLOTS-1:0]  pending, pending_d;
  logic [PTR_W-1:0]      ptr, ptr_d, arb_ptr;
  logic [NUM_SLOTS-1:0]  eligible, arb_grant;
  logic [NUM_SLOTS-1:0]  can_spawn_d;
  logic [TYPE_W-1:0]     type_d, next_type;
  logic [WAVE_W-1:0]     wave_d;
  logic                  done_d;
  logic [DIV_W-1:0]      div, div_nxt;

  // A slot just granted keeps reporting dead briefly; pending masks it until it comes alive.
  assign eligible = slotDead & ~pending;

  rr_slot_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req      (eligible),
    .ptr      (ptr),
    .grant    (arb_grant),
    .next_ptr (arb_ptr)
  );

`ifdef SPAWN_LFSR_EN
  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else if (enable) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign next_type = lfsr_type(lfsr[2:0], waveNum);
`else
  assign next_type = det_type(waveNum, spawn_cnt[0], spawn_cnt == LAST_K);
`endif

  // Next-state and next-output logic; enable low holds everything and idles the pulses.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    spawn_cnt_d = spawn_cnt;
    ptr_d       = ptr;
    wave_d      = waveNum;
    pending_d   = pending;
    can_spawn_d = '0;
    type_d      = TYPE_NONE;
    done_d      = 1'b0;
    if (enable) begin
      pending_d = pending & slotDead;
      case (state)
        QIdle: begin
          state_d = QCooldown;
          cnt_d   = COOL_LOAD;
        end
        QCooldown: begin
          if (cnt == '0) state_d = QSpawn;
          else           cnt_d   = cnt - CNT_W'(1);
        end
        QSpawn: begin
          if (|arb_grant) begin
            can_spawn_d = arb_grant;
            type_d      = next_type;
            pending_d   = pending_d | arb_grant;
            ptr_d       = arb_ptr;
            spawn_cnt_d = spawn_cnt + SPAWN_W'(1);
            if (spawn_cnt_d == WAVE_COUNT) begin
              state_d = QWaveWait;
            end else begin
              state_d = QCooldown;
              cnt_d   = COOL_LOAD;
            end
          end
        end
        QWaveWait: begin
          if ((&slotDead) && (pending == '0)) begin
            done_d      = 1'b1;
            wave_d      = (waveNum == WAVE_MAX) ? waveNum : waveNum + WAVE_W'(1);
            spawn_cnt_d = '0;
            state_d     = QWaveGap;
            cnt_d       = GAP_LOAD;
          end
        end
        QWaveGap: begin
          if (cnt == '0) begin
            state_d = QCooldown;
            cnt_d   = COOL_LOAD;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        default: state_d = QIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= QIdle;
      cnt       <= '0;
      spawn_cnt <= '0;
      pending   <= '0;
      ptr       <= '0;
      canSpawn  <= '0;
      spawnType <= TYPE_NONE;
      waveNum   <= '0;
      waveDone  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      spawn_cnt <= spawn_cnt_d;
      pending   <= pending_d;
      ptr       <= ptr_d;
      canSpawn  <= can_spawn_d;
      spawnType <= type_d;
      waveNum   <= wave_d;
      waveDone  <= done_d;
    end
  end

  // Free-running strobe divider; damage trails move by one cycle even across a freeze.
  assign div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= '0;
      moveSCEN   <= 1'b0;
      damageSCEN <= 1'b0;
    end else begin
      damageSCEN <= moveSCEN;
      if (enable) begin
        div      <= div_nxt;
        moveSCEN <= (div_nxt == DIV_LAST);
      end else begin
        moveSCEN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Scoreboard bench for enemy_wave_scheduler: expected grants queued as stimulus is applied,
// strobes checked every cycle against an enabled-edge count.
module tb_enemy_wave_scheduler;
  import enemy_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] slotDead;
  logic [3:0] canSpawn;
  logic [1:0] spawnType;
  logic       moveSCEN;
  logic       damageSCEN;
  logic [3:0] waveNum;
  logic       waveDone;

  enemy_wave_scheduler #(
    .NUM_SLOTS      (4),
    .SPAWN_COOLDOWN (8),
    .MOVE_DIV       (4),
    .WAVE_LEN       (3),
    .WAVE_GAP       (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .slotDead   (slotDead),
    .canSpawn   (canSpawn),
    .spawnType  (spawnType),
    .moveSCEN   (moveSCEN),
    .damageSCEN (damageSCEN),
    .waveNum    (waveNum),
    .waveDone   (waveDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] slots;
    logic [1:0] typ;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         en_edges = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         grant_cnt = 0;
  int         timer[4] = '{0, 0, 0, 0};
  bit         auto_kill = 1'b1;
  logic       prev_move = 1'b0;
  logic       exp_move = 1'b0;
  logic       exp_dmg = 1'b0;
  logic [3:0] exp_wave = 4'd0;
  logic [3:0] dead = 4'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input logic [3:0] slots, input logic [1:0] typ, input int due);
    exp_t e;
    e.slots = slots;
    e.typ   = typ;
    e.due   = due;
    sb.push_back(e);
  endtask

  task automatic set_dead(input logic [3:0] v);
    dead     = v;
    slotDead = v;
  endtask

  // One clock: advance the strobe model, sample at negedge, score grants, run slot models.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    if (reset) begin
      en_edges  = 0;
      exp_move  = 1'b0;
      exp_dmg   = 1'b0;
      prev_move = 1'b0;
    end else begin
      exp_dmg = prev_move;
      if (enable) begin
        en_edges++;
        exp_move = (en_edges % 4 == 3);
      end else begin
        exp_move = 1'b0;
      end
      prev_move = exp_move;
    end
    @(negedge clk);
    check_eq("moveSCEN", moveSCEN, exp_move);
    check_eq("damageSCEN", damageSCEN, exp_dmg);
    if (canSpawn != 4'd0) begin
      grant_cnt++;
      if (sb.size() == 0) begin
        check_eq("spurious_grant", canSpawn, 4'd0);
      end else begin
        e = sb.pop_front();
        check_eq("grant_slot", canSpawn, e.slots);
        check_eq("grant_type", spawnType, e.typ);
        if (e.due >= 0) check_eq("grant_cycle", cyc, e.due);
      end
    end
    if (waveDone) begin
      done_cnt++;
      done_cyc = cyc;
      exp_wave = (exp_wave == 4'd15) ? exp_wave : exp_wave + 4'd1;
      check_eq("wave_num", waveNum, exp_wave);
    end
    for (int i = 0; i < 4; i++) begin
      if (canSpawn[i]) begin
        timer[i] = 2;
      end else if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0 && auto_kill) dead[i] = 1'b0;
      end
    end
    slotDead = dead;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) tick();
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_done(input int limit);
    int start;
    start = done_cnt;
    for (int i = 0; i < limit && done_cnt == start; i++) tick();
    check_eq("wave_done_seen", done_cnt, start + 1);
  endtask

  task automatic finish_wave();
    int start;
    start = done_cnt;
    repeat (4) tick();
    check_eq("wave_wait_holds", done_cnt, start);
    set_dead(4'hF);
    wait_done(8);
  endtask

  initial begin
    int en_cyc;
    int g0;
    int d0;
    reset    = 1'b1;
    enable   = 1'b0;
    slotDead = 4'd0;
    tick();
    tick();
    check_eq("rst_canSpawn", canSpawn, 4'd0);
    check_eq("rst_spawnType", spawnType, TYPE_NONE);
    check_eq("rst_move", moveSCEN, 1'b0);
    check_eq("rst_damage", damageSCEN, 1'b0);
    check_eq("rst_waveNum", waveNum, 4'd0);
    check_eq("rst_waveDone", waveDone, 1'b0);
    reset = 1'b0;
    tick();

    // Wave 0: all basic, 9 cycles apart starting 9 cycles after enable.
    set_dead(4'hF);
    enable = 1'b1;
    en_cyc = cyc + 1;
    push(4'b0001, TYPE_BASIC, en_cyc + 9);
    push(4'b0010, TYPE_BASIC, en_cyc + 18);
    push(4'b0100, TYPE_BASIC, en_cyc + 27);
    drain(40);
    finish_wave();

    // Wave 1 resumes at slot 3 after gap + cooldown.
    push(4'b1000, TYPE_BASIC, done_cyc + 25);
    push(4'b0001, TYPE_MID,   done_cyc + 34);
    push(4'b0010, TYPE_BASIC, done_cyc + 43);
    drain(60);
    finish_wave();

    // Wave 2 closes with a boss.
    push(4'b0100, TYPE_BASIC, done_cyc + 25);
    push(4'b1000, TYPE_MID,   done_cyc + 34);
    push(4'b0001, TYPE_BOSS,  done_cyc + 43);
    drain(60);
    finish_wave();

    // Wave 3: no slot free through gap, cooldown and 20 cycles of QSpawn.
    set_dead(4'h0);
    g0 = grant_cnt;
    repeat (45) tick();
    check_eq("starve_no_grant", grant_cnt, g0);
    set_dead(4'b0100);
    push(4'b0100, TYPE_BASIC, cyc + 1);
    tick();
    check_eq("release_grant", sb.size(), 0);

    // Slot 0 stays dead after its grant; pending must block a re-grant.
    auto_kill = 1'b0;
    set_dead(4'b0001);
    push(4'b0001, TYPE_MID, cyc + 9);
    drain(15);
    g0 = grant_cnt;
    repeat (30) tick();
    check_eq("pending_blocks", grant_cnt, g0);
    set_dead(4'b0000);
    tick();
    set_dead(4'b0001);
    push(4'b0001, TYPE_BOSS, cyc + 1);
    tick();
    check_eq("regrant_after_alive", sb.size(), 0);
    set_dead(4'b0000);
    tick();

    // Freeze for 5 cycles: no waveDone, no strobes, divider phase held.
    enable = 1'b0;
    set_dead(4'hF);
    d0 = done_cnt;
    repeat (5) tick();
    check_eq("frozen_no_done", done_cnt, d0);
    enable = 1'b1;
    wait_done(4);

    // Reset in the middle of the cooldown that follows the gap.
    repeat (20) tick();
    reset = 1'b1;
    #1;
    check_eq("mid_rst_canSpawn", canSpawn, 4'd0);
    check_eq("mid_rst_spawnType", spawnType, TYPE_NONE);
    check_eq("mid_rst_move", moveSCEN, 1'b0);
    check_eq("mid_rst_damage", damageSCEN, 1'b0);
    check_eq("mid_rst_waveNum", waveNum, 4'd0);
    check_eq("mid_rst_waveDone", waveDone, 1'b0);
    exp_wave = 4'd0;
    tick();
    reset = 1'b0;
    set_dead(4'hF);
    en_cyc = cyc + 1;
    push(4'b0001, TYPE_BASIC, en_cyc + 9);
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
